// File: rtl/zombie_lane_engine_pkg.sv
// Shared definitions for the zombie lane engine.
//   state_t    : one-hot level FSM encoding (drives the q_* display outputs directly)
//   is_level   : true in the three playable states, where spawn/hit/move are live
//   sat_add16  : 16-bit saturating add used for the game-wide kill counter
package zombie_lane_engine_pkg;

    typedef enum logic [7:0] {
        S_I     = 8'h01,
        S_L1    = 8'h02,
        S_NL2   = 8'h04,
        S_L2    = 8'h08,
        S_NL3   = 8'h10,
        S_L3    = 8'h20,
        S_DONEL = 8'h40,
        S_DONEW = 8'h80
    } state_t;

    localparam logic [15:0] KILLED_MAX = 16'hFFFF;

    function automatic logic is_level(input state_t s);
        return (s == S_L1) || (s == S_L2) || (s == S_L3);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [7:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {9'b0, b};
        return s[16] ? KILLED_MAX : s[15:0];
    endfunction

endpackage

// File: rtl/zombie_lane_engine_lane.sv
// One zombie slot (one lane).
//   clk, reset : clock, async active-high reset
//   en         : lane logic live (playable level)
//   clear      : wipe the slot this edge (leaving a level); beats everything else
//   hit/move/spawn : per-cycle events, applied in priority hit > move > spawn
//   active, x  : registered slot state
//   kill       : live zombie hit this cycle (combinational, counted by the top)
//   at_end     : this cycle's move would land the zombie on END_X without a hit
module zombie_lane_engine_lane #(
    parameter int unsigned      X_W     = 10,
    parameter logic [X_W-1:0]   SPAWN_X = 10'd639,
    parameter logic [X_W-1:0]   END_X   = 10'd0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           clear,
    input  logic           hit,
    input  logic           move,
    input  logic           spawn,
    output logic           active,
    output logic [X_W-1:0] x,
    output logic           kill,
    output logic           at_end
);

    localparam logic [X_W-1:0] END_X_P1 = END_X + X_W'(1);

    assign kill   = en & active & hit;
    assign at_end = en & active & ~hit & move & (x == END_X_P1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            x      <= SPAWN_X;
        end else if (clear) begin
            active <= 1'b0;
            x      <= SPAWN_X;
        end else if (en) begin
            if (active && hit) begin
                active <= 1'b0;
                x      <= SPAWN_X;
            end else if (active && move) begin
                // Saturate at the lawn end; the top turns arrival into a loss anyway.
                if (x != END_X) x <= x - X_W'(1);
            end else if (!active && spawn) begin
                active <= 1'b1;
                x      <= SPAWN_X;
            end
        end
    end

endmodule

// File: rtl/zombie_lane_engine.sv
// Game-state and zombie-motion engine.
//   clk, reset      : clock, async active-high reset
//   start           : pulse that advances out of I / NLx / DoneL / DoneW
//   spawn_req, hit  : per-lane spawn and kill pulses
//   zombie_active   : per-lane live flag
//   zombie_x        : lane i X at [i*X_W +: X_W]
//   zombies_killed  : saturating game kill total
//   move_tick       : one-cycle pulse following each move step
//   q_*             : one-hot FSM state
module zombie_lane_engine
    import zombie_lane_engine_pkg::*;
#(
    parameter int unsigned      NUM_LANES       = 5,
    parameter int unsigned      X_W             = 10,
    parameter logic [X_W-1:0]   SPAWN_X         = 10'd639,
    parameter logic [X_W-1:0]   END_X           = 10'd0,
    parameter int unsigned      TICK_L1         = 500000,
    parameter int unsigned      TICK_L2         = 350000,
    parameter int unsigned      TICK_L3         = 200000,
    parameter int unsigned      KILLS_PER_LEVEL = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_LANES-1:0]     spawn_req,
    input  logic [NUM_LANES-1:0]     hit,
    output logic [NUM_LANES-1:0]     zombie_active,
    output logic [NUM_LANES*X_W-1:0] zombie_x,
    output logic [15:0]              zombies_killed,
    output logic                     move_tick,
    output logic                     q_I,
    output logic                     q_L1,
    output logic                     q_NL2,
    output logic                     q_L2,
    output logic                     q_NL3,
    output logic                     q_L3,
    output logic                     q_DoneL,
    output logic                     q_DoneW
);

    state_t                          state, state_next;
    logic                            in_lvl;
    logic [31:0]                     tick_cnt, tick_max;
    logic                            wrap;
    logic [NUM_LANES-1:0]            kill_vec, at_end_vec;
    logic [NUM_LANES-1:0][X_W-1:0]   x_arr;
    logic [7:0]                      kills;
    logic [7:0]                      lvl_kills;
    logic [8:0]                      lvl_sum;
    logic                            level_done, loss, lane_clear;

    assign in_lvl = is_level(state);

    always_comb begin
        tick_max = 32'(TICK_L1);
        case (state)
            S_L2:    tick_max = 32'(TICK_L2);
            S_L3:    tick_max = 32'(TICK_L3);
            default: tick_max = 32'(TICK_L1);
        endcase
    end

    assign wrap = in_lvl && (tick_cnt == tick_max - 32'd1);

    // Lanes wipe on the same edge the FSM leaves a level, so NLx/DoneL/DoneW/I
    // are entered with an empty lawn.
    assign lane_clear = !is_level(state_next);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            zombie_lane_engine_lane #(
                .X_W     (X_W),
                .SPAWN_X (SPAWN_X),
                .END_X   (END_X)
            ) u_lane (
                .clk    (clk),
                .reset  (reset),
                .en     (in_lvl),
                .clear  (lane_clear),
                .hit    (hit[gi]),
                .move   (wrap),
                .spawn  (spawn_req[gi]),
                .active (zombie_active[gi]),
                .x      (x_arr[gi]),
                .kill   (kill_vec[gi]),
                .at_end (at_end_vec[gi])
            );
        end
    endgenerate

    assign zombie_x = x_arr;

    always_comb begin
        kills = 8'd0;
        for (int i = 0; i < int'(NUM_LANES); i++) kills = kills + 8'(kill_vec[i]);
    end

    assign lvl_sum    = {1'b0, lvl_kills} + {1'b0, kills};
    assign level_done = lvl_sum >= 9'(KILLS_PER_LEVEL);
    assign loss       = |at_end_vec;

    // Loss is tested before level-clear so a simultaneous loss wins.
    always_comb begin
        state_next = state;
        case (state)
            S_I:     if (start) state_next = S_L1;
            S_L1:    if (loss) state_next = S_DONEL; else if (level_done) state_next = S_NL2;
            S_NL2:   if (start) state_next = S_L2;
            S_L2:    if (loss) state_next = S_DONEL; else if (level_done) state_next = S_NL3;
            S_NL3:   if (start) state_next = S_L3;
            S_L3:    if (loss) state_next = S_DONEL; else if (level_done) state_next = S_DONEW;
            S_DONEL: if (start) state_next = S_I;
            S_DONEW: if (start) state_next = S_I;
            default: state_next = S_I;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_I;
            tick_cnt       <= 32'd0;
            move_tick      <= 1'b0;
            lvl_kills      <= 8'd0;
            zombies_killed <= 16'd0;
        end else begin
            state     <= state_next;
            move_tick <= wrap;
            // Counter only runs while staying in a level, so every entry starts at 0.
            if (in_lvl && state_next == state) tick_cnt <= wrap ? 32'd0 : tick_cnt + 32'd1;
            else                               tick_cnt <= 32'd0;
            lvl_kills <= is_level(state_next) ? lvl_sum[7:0] : 8'd0;
            if (state == S_I && start) zombies_killed <= 16'd0;
            else if (in_lvl)           zombies_killed <= sat_add16(zombies_killed, kills);
        end
    end

    assign q_I     = (state == S_I);
    assign q_L1    = (state == S_L1);
    assign q_NL2   = (state == S_NL2);
    assign q_L2    = (state == S_L2);
    assign q_NL3   = (state == S_NL3);
    assign q_L3    = (state == S_L3);
    assign q_DoneL = (state == S_DONEL);
    assign q_DoneW = (state == S_DONEW);

endmodule

// File: tb/tb_zombie_lane_engine.sv
module tb_zombie_lane_engine;

    localparam int         NL = 5;
    localparam int         XW = 10;
    localparam logic [9:0] SX = 10'd20;

    logic            clk, reset, start;
    logic [NL-1:0]   spawn_req, hit;
    logic [NL-1:0]   zombie_active;
    logic [NL*XW-1:0] zombie_x;
    logic [15:0]     zombies_killed;
    logic            move_tick;
    logic            q_I, q_L1, q_NL2, q_L2, q_NL3, q_L3, q_DoneL, q_DoneW;

    zombie_lane_engine #(
        .NUM_LANES(NL), .X_W(XW), .SPAWN_X(SX), .END_X(10'd0),
        .TICK_L1(8), .TICK_L2(6), .TICK_L3(4), .KILLS_PER_LEVEL(3)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .spawn_req(spawn_req), .hit(hit),
        .zombie_active(zombie_active), .zombie_x(zombie_x), .zombies_killed(zombies_killed),
        .move_tick(move_tick), .q_I(q_I), .q_L1(q_L1), .q_NL2(q_NL2), .q_L2(q_L2),
        .q_NL3(q_NL3), .q_L3(q_L3), .q_DoneL(q_DoneL), .q_DoneW(q_DoneW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic push(input string t, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty observed %0h", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic spawn(input logic [NL-1:0] m);
        spawn_req = m; cyc(); spawn_req = '0;
    endtask

    task automatic hit_lanes(input logic [NL-1:0] m);
        hit = m; cyc(); hit = '0;
    endtask

    function automatic logic [XW-1:0] xl(input int i);
        return zombie_x[i*XW +: XW];
    endfunction

    logic [NL*XW-1:0] all_spawn;
    int               cyc_n, ticks;
    logic [XW-1:0]    x_last;

    initial begin
        all_spawn = {NL{SX}};
        reset = 1'b1; start = 1'b0; spawn_req = '0; hit = '0;
        repeat (2) cyc();

        // reset state
        push("rst_q_I", 1); push("rst_active", 0); push("rst_killed", 0);
        push("rst_tick", 0); push("rst_x", 64'(all_spawn));
        pop_check(64'(q_I)); pop_check(64'(zombie_active)); pop_check(64'(zombies_killed));
        pop_check(64'(move_tick)); pop_check(64'(zombie_x));
        reset = 1'b0; cyc();

        // start, spawn lane 2, first move after 8 cycles in L1
        push("t2_q_L1", 1);
        pulse_start();
        pop_check(64'(q_L1));
        push("t2_spawn_act", 64'(5'b00100)); push("t2_spawn_x", 20);
        spawn(5'b00100);
        pop_check(64'(zombie_active)); pop_check(64'(xl(2)));
        push("t2_pre_tick", 0); push("t2_pre_x", 20);
        repeat (6) cyc();
        pop_check(64'(move_tick)); pop_check(64'(xl(2)));
        push("t2_tick", 1); push("t2_x19", 19);
        cyc();
        pop_check(64'(move_tick)); pop_check(64'(xl(2)));
        push("t2_tick_off", 0);
        cyc();
        pop_check(64'(move_tick));

        // three hits in one cycle clear L1
        push("t3_act", 64'(5'b01111));
        spawn(5'b01011);
        pop_check(64'(zombie_active));
        push("t3_killed", 3); push("t3_q_NL2", 1); push("t3_act_clr", 0); push("t3_x_clr", 64'(all_spawn));
        hit_lanes(5'b01011);
        pop_check(64'(zombies_killed)); pop_check(64'(q_NL2));
        pop_check(64'(zombie_active)); pop_check(64'(zombie_x));

        // lone zombie walks to the lawn end
        reset = 1'b1; cyc(); reset = 1'b0; cyc();
        pulse_start();
        spawn(5'b00001);
        push("t4_doneL", 1); push("t4_cycles", 159); push("t4_ticks", 19);
        push("t4_last_x", 1); push("t4_act", 0);
        cyc_n = 0; ticks = 0; x_last = '0;
        while (!q_DoneL && cyc_n < 400) begin
            x_last = xl(0);
            cyc(); cyc_n++;
            if (move_tick && !q_DoneL) ticks++;
        end
        pop_check(64'(q_DoneL)); pop_check(64'(cyc_n)); pop_check(64'(ticks));
        pop_check(64'(x_last)); pop_check(64'(zombie_active));
        push("t4_q_I", 1);
        pulse_start();
        pop_check(64'(q_I));

        // hit at x=1 on a move cycle beats the loss; hit on idle lane scores nothing
        pulse_start();
        spawn(5'b00001);
        push("t5_x1", 1); push("t5_pre_tick", 0);
        repeat (158) cyc();
        pop_check(64'(xl(0))); pop_check(64'(move_tick));
        push("t5_q_L1", 1); push("t5_act", 0); push("t5_killed", 1); push("t5_tick", 1);
        hit_lanes(5'b00001);
        pop_check(64'(q_L1)); pop_check(64'(zombie_active));
        pop_check(64'(zombies_killed)); pop_check(64'(move_tick));
        push("t5_no_doneL", 0);
        repeat (10) cyc();
        pop_check(64'(q_DoneL));
        push("t5_idle_hit", 1);
        hit_lanes(5'b01000);
        pop_check(64'(zombies_killed));

        // play through all levels
        spawn(5'b00011);
        push("t6_q_NL2", 1); push("t6_k3", 3);
        hit_lanes(5'b00011);
        pop_check(64'(q_NL2)); pop_check(64'(zombies_killed));
        push("t6_q_L2", 1);
        pulse_start();
        pop_check(64'(q_L2));
        push("t6_start_ign", 1);
        pulse_start();
        pop_check(64'(q_L2));
        spawn(5'b00011);
        push("t6_k5", 5); push("t6_stay_L2", 1); push("t6_act0", 0);
        hit_lanes(5'b10011);
        pop_check(64'(zombies_killed)); pop_check(64'(q_L2)); pop_check(64'(zombie_active));
        spawn(5'b00100);
        push("t6_q_NL3", 1); push("t6_k6", 6);
        hit_lanes(5'b00100);
        pop_check(64'(q_NL3)); pop_check(64'(zombies_killed));
        push("t6_q_L3", 1);
        pulse_start();
        pop_check(64'(q_L3));
        spawn(5'b00111);
        push("t6_q_DoneW", 1); push("t6_k9", 9);
        hit_lanes(5'b00111);
        pop_check(64'(q_DoneW)); pop_check(64'(zombies_killed));
        push("t6_q_I", 1); push("t6_k9_hold", 9);
        pulse_start();
        pop_check(64'(q_I)); pop_check(64'(zombies_killed));
        push("t6_new_game_k0", 0);
        pulse_start();
        pop_check(64'(zombies_killed));

        // async reset in the middle of L2 with lanes active
        spawn(5'b00111);
        hit_lanes(5'b00111);
        pulse_start();
        push("t1_pre_L2", 1); push("t1_pre_act", 64'(5'b00011));
        spawn(5'b00011);
        pop_check(64'(q_L2)); pop_check(64'(zombie_active));
        push("t1_q_I", 1); push("t1_q_L2", 0); push("t1_act", 0);
        push("t1_killed", 0); push("t1_x", 64'(all_spawn));
        #2 reset = 1'b1;
        #1;
        pop_check(64'(q_I)); pop_check(64'(q_L2)); pop_check(64'(zombie_active));
        pop_check(64'(zombies_killed)); pop_check(64'(zombie_x));
        cyc(); reset = 1'b0; cyc();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
